// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with busy scoreboard.
//
// Purpose
//   NRD combinational read ports, two synchronous write ports (A = ALU
//   writeback, B = load writeback) and a per-register busy scoreboard used by
//   the issue stage for hazard detection. After reset a clear sequencer zeroes
//   one entry per cycle; ready rises once every entry has been cleared.
//
// Optional feature
//   RF_BYPASS_EN : write-first forwarding. A same-cycle write to a read
//                  address is forwarded to rv (port B over port A), and a
//                  same-cycle retiring write masks rs_busy unless the same
//                  register is also being re-issued.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous, active-low reset
//   ready      out  high once the post-reset clear sequence completes
//   rs_addr    in   NRD*AW read addresses, port i at [i*AW +: AW]
//   rv         out  NRD*XLEN read data, port i at [i*XLEN +: XLEN]
//   rs_busy    out  NRD busy bits of the registers addressed by rs_addr
//   we_a/rd_a/wdata_a  in  write port A (enable, address, data)
//   we_b/rd_b/wdata_b  in  write port B (enable, address, data)
//   iss_valid  in   an instruction issues that writes iss_rd
//   iss_rd     in   destination of the issuing instruction
//   iss_waw    out  combinational busy[iss_rd] (WAW hazard flag)
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rv,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we_a,
   input  logic [AW-1:0]       rd_a,
   input  logic [XLEN-1:0]     wdata_a,
   input  logic                we_b,
   input  logic [AW-1:0]       rd_b,
   input  logic [XLEN-1:0]     wdata_b,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_waw
);

   localparam int NREG = 2**AW;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [AW-1:0]       r_clr_idx;
   logic                r_ready;
   logic [XLEN-1:0]     r_mem [NREG];
   logic [NREG-1:0]     r_busy;

   logic                w_run;
   logic                w_wr_a;
   logic                w_wr_b;
   logic                w_iss;

   assign w_run  = (r_state == ST_RUN);
   // Qualified write/issue strobes: ignored while clearing, and register 0
   // is hard-wired when ZERO_REG is set.
   assign w_wr_a = w_run && we_a && !((ZERO_REG != 0) && (rd_a == '0));
   assign w_wr_b = w_run && we_b && !((ZERO_REG != 0) && (rd_b == '0));
   assign w_iss  = w_run && iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));

   // -------------------------------------------------------------------------
   // Control FSM: CLEAR walks every index once, then RUN until next reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == {AW{1'b1}}) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_CLEAR;
            end
         endcase
      end
   end

   assign ready = r_ready;

   // -------------------------------------------------------------------------
   // Storage array.
   // NOTE: the array has no reset branch; zeroing is done by the clear
   // sequencer one entry per cycle so the array can map onto plain RAM/flops
   // without a wide reset fan-out.
   // Port B is written after port A so it wins on an address collision.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
         end else begin
            if (w_wr_a) r_mem[rd_a] <= wdata_a;
            if (w_wr_b) r_mem[rd_b] <= wdata_b;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Busy scoreboard: a new issue (set) supersedes a retiring write (clear).
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if ((ZERO_REG != 0) && (r == 0)) begin
               r_busy[r] <= 1'b0;
            end else if (w_iss && (iss_rd == AW'(r))) begin
               r_busy[r] <= 1'b1;
            end else if ((w_wr_a && (rd_a == AW'(r))) ||
                         (w_wr_b && (rd_b == AW'(r)))) begin
               r_busy[r] <= 1'b0;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read ports: combinational, gated to zero while clearing.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_addr = rs_addr[gi*AW +: AW];

      // NOTE: both outputs get a default first so no path leaves them
      // unassigned and no latch is inferred.
      always_comb begin
         w_data = r_mem[w_addr];
         w_busy = r_busy[w_addr];
`ifdef RF_BYPASS_EN
         if (w_wr_b && (rd_b == w_addr)) begin
            w_data = wdata_b;
         end else if (w_wr_a && (rd_a == w_addr)) begin
            w_data = wdata_a;
         end
         if (((w_wr_a && (rd_a == w_addr)) || (w_wr_b && (rd_b == w_addr))) &&
             !(w_iss && (iss_rd == w_addr))) begin
            w_busy = 1'b0;
         end
`endif
         if (!w_run || ((ZERO_REG != 0) && (w_addr == '0))) begin
            w_data = '0;
            w_busy = 1'b0;
         end
      end

      assign rv[gi*XLEN +: XLEN] = w_data;
      assign rs_busy[gi]         = w_busy;
   end

   assign iss_waw = w_run && r_busy[iss_rd];

endmodule
